// File: rtl/ctl_fsm_ws_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctl_pkg
// Brief    : Opcodes, FSM state encodings and strobe bundle for ctl_fsm_ws.
// Revision : 1.0  initial release
// ============================================================================
package ctl_pkg;

    localparam logic [2:0] HLT  = 3'd0;
    localparam logic [2:0] SKZ  = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] ANDD = 3'd3;
    localparam logic [2:0] XORR = 3'd4;
    localparam logic [2:0] LDA  = 3'd5;
    localparam logic [2:0] STO  = 3'd6;
    localparam logic [2:0] JMP  = 3'd7;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_OPER   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_SKIP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    typedef struct packed {
        logic halt;
        logic datactl_ena;
        logic load_ir;
        logic wr;
        logic rd;
        logic load_pc;
        logic load_acc;
        logic inc_pc;
    } ctl_strb_t;

    function automatic logic is_alu_rd(input logic [2:0] op);
        return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctl_fsm_ws_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : ctl_wait_timer
// Brief    : Bus-wait watchdog; flags the WAIT_MAX-th consecutive wait cycle.
// Revision : 1.0  initial release
// ============================================================================
module ctl_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int c_cnt_w = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WAIT_MAX - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (WAIT_MAX > 0)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the wait cycle that would bring the count to WAIT_MAX.
    assign expired = (WAIT_MAX > 0) && inc && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ctl_fsm_ws.sv
`default_nettype none
// ============================================================================
// Module   : ctl_fsm_ws
// Brief    : CPU control FSM with multi-word fetch, wait states, bus watchdog
//            and resumable halt. All outputs registered on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module ctl_fsm_ws
    import ctl_pkg::*;
#(
    parameter int FETCH_WORDS = 2,
    parameter int WAIT_MAX    = 15
) (
    input  logic       clk1,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic [1:0] fetch_idx,
    output logic       bus_err
);

    localparam logic [1:0] c_last_word = 2'(FETCH_WORDS - 1);

    logic [2:0] r_state, w_state;
    logic [1:0] r_idx, w_idx;
    logic [1:0] r_skip, w_skip;
    ctl_strb_t  r_strb, w_strb;
    logic       r_bus_err, w_bus_err;

    logic w_wait, w_inc, w_clr, w_expired;

    assign w_wait = (r_state == S_FETCH) ||
                    ((r_state == S_OPER) && (is_alu_rd(opcode) || (opcode == STO)));
    assign w_inc  = w_wait && !mem_ready;
    assign w_clr  = !w_inc || w_expired;

    ctl_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk1),
        .rst_n   (ena),
        .clr     (w_clr),
        .inc     (w_inc),
        .expired (w_expired)
    );

    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_skip    = r_skip;
        w_strb    = '0;
        w_bus_err = r_bus_err;
        case (r_state)
            S_FETCH: begin
                if (w_expired) begin
                    w_state     = S_HALT;
                    w_idx       = 2'd0;
                    w_strb.halt = 1'b1;
                    w_bus_err   = 1'b1;
                end else if (mem_ready) begin
                    if (r_idx == c_last_word) begin
                        w_state = S_DECODE;
                        w_idx   = 2'd0;
                    end else begin
                        // inc_pc only on entry to the next word, never while holding
                        w_idx          = r_idx + 2'd1;
                        w_strb.rd      = 1'b1;
                        w_strb.load_ir = 1'b1;
                        w_strb.inc_pc  = 1'b1;
                    end
                end else begin
                    w_strb.rd      = 1'b1;
                    w_strb.load_ir = 1'b1;
                end
            end
            S_DECODE: begin
                w_state       = S_ADDR;
                w_strb.inc_pc = 1'b1;
                w_strb.halt   = (opcode == HLT);
            end
            S_ADDR: begin
                if (opcode == HLT) begin
                    w_state     = S_HALT;
                    w_strb.halt = 1'b1;
                end else begin
                    w_state = S_OPER;
                    if (is_alu_rd(opcode)) begin
                        w_strb.rd = 1'b1;
                    end else if (opcode == STO) begin
                        w_strb.wr          = 1'b1;
                        w_strb.datactl_ena = 1'b1;
                    end else if (opcode == JMP) begin
                        w_strb.load_pc = 1'b1;
                    end
                end
            end
            S_OPER: begin
                if (is_alu_rd(opcode) || (opcode == STO)) begin
                    if (w_expired) begin
                        w_state     = S_HALT;
                        w_strb.halt = 1'b1;
                        w_bus_err   = 1'b1;
                    end else if (mem_ready) begin
                        w_state = S_WB;
                        if (opcode == STO) begin
                            w_strb.datactl_ena = 1'b1;
                        end else begin
                            w_strb.rd       = 1'b1;
                            w_strb.load_acc = 1'b1;
                        end
                    end else if (opcode == STO) begin
                        w_strb.wr          = 1'b1;
                        w_strb.datactl_ena = 1'b1;
                    end else begin
                        w_strb.rd = 1'b1;
                    end
                end else if (opcode == JMP) begin
                    w_state        = S_WB;
                    w_strb.inc_pc  = 1'b1;
                    w_strb.load_pc = 1'b1;
                end else if ((opcode == SKZ) && zero) begin
                    w_state       = S_SKIP;
                    w_skip        = 2'd0;
                    w_strb.inc_pc = 1'b1;
                end else begin
                    w_state        = S_FETCH;
                    w_idx          = 2'd0;
                    w_strb.rd      = 1'b1;
                    w_strb.load_ir = 1'b1;
                end
            end
            S_WB: begin
                w_state        = S_FETCH;
                w_idx          = 2'd0;
                w_strb.rd      = 1'b1;
                w_strb.load_ir = 1'b1;
            end
            S_SKIP: begin
                if (r_skip == c_last_word) begin
                    w_state        = S_FETCH;
                    w_idx          = 2'd0;
                    w_strb.rd      = 1'b1;
                    w_strb.load_ir = 1'b1;
                end else begin
                    w_skip        = r_skip + 2'd1;
                    w_strb.inc_pc = 1'b1;
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_state        = S_FETCH;
                    w_idx          = 2'd0;
                    w_bus_err      = 1'b0;
                    w_strb.rd      = 1'b1;
                    w_strb.load_ir = 1'b1;
                end else begin
                    w_strb.halt = 1'b1;
                end
            end
            default: begin
                w_state = S_FETCH;
                w_idx   = 2'd0;
                w_skip  = 2'd0;
            end
        endcase
    end

    always_ff @(negedge clk1 or negedge ena) begin
        if (!ena) begin
            r_state   <= S_FETCH;
            r_idx     <= 2'd0;
            r_skip    <= 2'd0;
            r_strb    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_skip    <= w_skip;
            r_strb    <= w_strb;
            r_bus_err <= w_bus_err;
        end
    end

    assign inc_pc      = r_strb.inc_pc;
    assign load_acc    = r_strb.load_acc;
    assign load_pc     = r_strb.load_pc;
    assign rd          = r_strb.rd;
    assign wr          = r_strb.wr;
    assign load_ir     = r_strb.load_ir;
    assign datactl_ena = r_strb.datactl_ena;
    assign halt        = r_strb.halt;
    assign fetch_idx   = r_idx;
    assign bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_ctl_fsm_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctl_fsm_ws
// Brief    : Randomised instruction-stream bench for ctl_fsm_ws with an
//            instruction-level reference model feeding a per-cycle scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctl_fsm_ws;

    localparam int FW = 3;
    localparam int WM = 7;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3;
    localparam logic [2:0] XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    localparam logic [7:0] B_INC  = 8'h01;
    localparam logic [7:0] B_LACC = 8'h02;
    localparam logic [7:0] B_LPC  = 8'h04;
    localparam logic [7:0] B_RD   = 8'h08;
    localparam logic [7:0] B_WR   = 8'h10;
    localparam logic [7:0] B_LIR  = 8'h20;
    localparam logic [7:0] B_DCTL = 8'h40;
    localparam logic [7:0] B_HALT = 8'h80;

    logic       clk1 = 1'b1;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
    logic [1:0] fetch_idx;
    logic       bus_err;

    always #5 clk1 = ~clk1;

    ctl_fsm_ws #(
        .FETCH_WORDS (FW),
        .WAIT_MAX    (WM)
    ) dut (
        .clk1        (clk1),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .resume      (resume),
        .inc_pc      (inc_pc),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .fetch_idx   (fetch_idx),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [8:0] v;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cycle  = 0;
    logic m_bus_err = 1'b0;
    bit   m_after_rst = 1'b0;
    int   force_w = -1;
    int   force_h = -1;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic int pick_w();
        int r;
        if (force_w >= 0) return force_w;
        r = int'($urandom_range(0, 99));
        if (r < 60) return 0;
        if (r < 85) return int'($urandom_range(1, 3));
        if (r < 92) return WM - 1;
        return int'($urandom_range(WM, WM + 3));
    endfunction

    // One clock cycle of stimulus plus the strobes expected during that cycle.
    task automatic cyc(input logic [7:0] s, input int idx, input logic mr,
                       input logic [2:0] op, input logic zr, input logic rs);
        exp_t e;
        @(posedge clk1);
        ena       = 1'b1;
        mem_ready = mr;
        opcode    = op;
        zero      = zr;
        resume    = rs;
        e.v   = {m_bus_err, s};
        e.idx = idx;
        q.push_back(e);
    endtask

    task automatic rst_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            ena       = 1'b0;
            mem_ready = rbit();
            opcode    = rop();
            zero      = rbit();
            resume    = rbit();
            m_bus_err = 1'b0;
            e.v   = 9'h000;
            e.idx = 0;
            q.push_back(e);
        end
        m_after_rst = 1'b1;
    endtask

    // A memory access that stalls w cycles; times out on the WM-th stalled cycle.
    task automatic wait_phase(input logic [7:0] first, input logic [7:0] hold,
                              input int idx, input bit op_rand, input logic [2:0] op,
                              output bit to);
        int w;
        w  = pick_w();
        to = (w >= WM);
        if (to) begin
            for (int i = 0; i < WM; i++)
                cyc((i == 0) ? first : hold, idx, 1'b0, op_rand ? rop() : op, rbit(), rbit());
        end else begin
            for (int i = 0; i < w; i++)
                cyc((i == 0) ? first : hold, idx, 1'b0, op_rand ? rop() : op, rbit(), rbit());
            cyc((w == 0) ? first : hold, idx, 1'b1, op_rand ? rop() : op, rbit(), rbit());
        end
    endtask

    task automatic halt_phase();
        int n;
        n = (force_h >= 0) ? force_h : int'($urandom_range(0, 4));
        for (int i = 0; i < n; i++)
            cyc(B_HALT, -1, rbit(), rop(), rbit(), 1'b0);
        cyc(B_HALT, -1, rbit(), rop(), rbit(), 1'b1);
        m_bus_err = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic zr, input bit inj_rst);
        bit         to;
        logic [7:0] first;
        for (int k = 0; k < FW; k++) begin
            if (k == 0 && m_after_rst) first = 8'h00;
            else first = B_RD | B_LIR | ((k > 0) ? B_INC : 8'h00);
            if (k == 0) m_after_rst = 1'b0;
            wait_phase(first, B_RD | B_LIR, k, 1'b1, op, to);
            if (to) begin
                m_bus_err = 1'b1;
                halt_phase();
                return;
            end
        end
        cyc(8'h00, -1, rbit(), op, rbit(), rbit());
        if (op == HLT) begin
            cyc(B_INC | B_HALT, -1, rbit(), op, rbit(), rbit());
            halt_phase();
            return;
        end
        cyc(B_INC, -1, rbit(), op, rbit(), rbit());
        case (op)
            SKZ: begin
                cyc(8'h00, -1, rbit(), op, zr, rbit());
                if (zr)
                    for (int i = 0; i < FW; i++)
                        cyc(B_INC, -1, rbit(), op, rbit(), rbit());
            end
            JMP: begin
                cyc(B_LPC, -1, rbit(), op, rbit(), rbit());
                cyc(B_INC | B_LPC, -1, rbit(), op, rbit(), rbit());
            end
            STO: begin
                if (inj_rst) begin
                    for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++)
                        cyc(B_WR | B_DCTL, -1, 1'b0, op, rbit(), rbit());
                    rst_cycles(2);
                    return;
                end
                wait_phase(B_WR | B_DCTL, B_WR | B_DCTL, -1, 1'b0, op, to);
                if (to) begin
                    m_bus_err = 1'b1;
                    halt_phase();
                    return;
                end
                cyc(B_DCTL, -1, rbit(), op, rbit(), rbit());
            end
            default: begin
                wait_phase(B_RD, B_RD, -1, 1'b0, op, to);
                if (to) begin
                    m_bus_err = 1'b1;
                    halt_phase();
                    return;
                end
                cyc(B_RD | B_LACC, -1, rbit(), op, rbit(), rbit());
            end
        endcase
    endtask

    // Monitor: one scoreboard entry per cycle, sampled between falling edges.
    always begin
        exp_t       e;
        logic [8:0] act;
        @(posedge clk1);
        #1;
        n_cycle++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus_err, halt, datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc};
            n_checks++;
            if (act !== e.v || (e.idx >= 0 && fetch_idx !== 2'(e.idx))) begin
                n_errors++;
                $display("FAIL cycle%0d {bus_err,halt,dctl,ir,wr,rd,lpc,lacc,inc} got=%b want=%b fetch_idx got=%0d want=%0d",
                         n_cycle, act, e.v, fetch_idx, e.idx);
            end
        end
    end

    initial begin
        ena       = 1'b0;
        opcode    = 3'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        resume    = 1'b0;
        rst_cycles(3);

        force_w = 0;   run_instr(ADD, 1'b0, 1'b0);
        force_w = 3;   run_instr(STO, 1'b0, 1'b0);
        force_w = 0;   run_instr(SKZ, 1'b1, 1'b0);
        run_instr(SKZ, 1'b0, 1'b0);
        force_h = 10;  run_instr(HLT, 1'b0, 1'b0);
        force_h = -1;
        force_w = 100; run_instr(LDA, 1'b0, 1'b0);
        force_w = WM - 1; run_instr(XORR, 1'b0, 1'b0);
        force_w = 0;   run_instr(JMP, 1'b0, 1'b0);
        run_instr(STO, 1'b0, 1'b1);
        run_instr(ANDD, 1'b0, 1'b0);
        force_w = -1;

        for (int i = 0; i < 300; i++)
            run_instr(rop(), rbit(), ($urandom_range(0, 29) == 0));

        repeat (3) @(posedge clk1);
        #2;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
